// File: rtl/spatial_encoder_pkg.sv
// Shared constants for the spatial encoder slice: hypervector width, channel
// width and the ceilLog2 helper, plus the package-level dimension parameter.
`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif
`ifndef ceilLog2
`define ceilLog2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package spatial_encoder_pkg;
  localparam int HV_DIM = `HV_DIMENSION;
endpackage

// File: rtl/spatial_encoder_majority_counter.sv
// One hypervector dimension: counts ones over a frame and registers the
// majority decision on the frame's last channel.
module majority_counter #(
  parameter int CNT_W  = 6,
  parameter int THRESH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic last,
  output logic hv_bit
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_sum;
  logic             r_hv;

  // The decision must include the bit arriving on the final fire.
  assign w_sum = {1'b0, r_cnt} + {{CNT_W{1'b0}}, inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_hv  <= 1'b0;
    end else begin
      if (clr)      r_cnt <= '0;
      else if (inc) r_cnt <= w_sum[CNT_W-1:0];
      if (last)     r_hv  <= (w_sum > (CNT_W+1)'(THRESH));
    end
  end

  assign hv_bit = r_hv;
endmodule

// File: rtl/spatial_encoder.sv
// Spatial encoder: bundles num_channel (im ^ projm) hypervectors per frame by
// per-dimension majority vote and hands the result downstream.
import spatial_encoder_pkg::*;

module spatial_encoder #(
  parameter int num_channel = 32,
  parameter int cnt_width   = `ceilLog2(num_channel+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [`HV_DIMENSION-1:0] im,
  input  logic [`HV_DIMENSION-1:0] projm,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [`HV_DIMENSION-1:0] hvout,
  output logic                     dout_valid,
  input  logic                     dout_ready
);
  localparam int CH_W   = `ceilLog2(num_channel);
  localparam int THRESH = num_channel / 2;

  typedef enum logic {ACCUM, OUTPUT} state_t;

  state_t            r_state, w_next;
  logic [CH_W-1:0]   r_chan;
  logic              w_din_fire, w_dout_fire, w_last;
  logic [HV_DIM-1:0] w_xor;

  assign w_din_fire  = din_valid && din_ready;
  assign w_dout_fire = dout_valid && dout_ready;
  assign w_last      = w_din_fire && (r_chan == CH_W'(num_channel - 1));
  assign w_xor       = im ^ projm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_next;
  end

  // Handshake outputs are decoded from state alone.
  always_comb begin
    w_next     = r_state;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    case (r_state)
      ACCUM: begin
        din_ready = 1'b1;
        if (w_last) w_next = OUTPUT;
      end
      OUTPUT: begin
        dout_valid = 1'b1;
        if (dout_ready) w_next = ACCUM;
      end
      default: w_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_chan <= '0;
    else if (w_last)     r_chan <= '0;
    else if (w_din_fire) r_chan <= r_chan + CH_W'(1);
  end

  for (genvar d = 0; d < HV_DIM; d++) begin : g_dim
    majority_counter #(
      .CNT_W  (cnt_width),
      .THRESH (THRESH)
    ) u_mc (
      .clk    (clk),
      .rst    (rst),
      .inc    (w_din_fire & w_xor[d]),
      .clr    (w_dout_fire),
      .last   (w_last),
      .hv_bit (hvout[d])
    );
  end
endmodule

// File: tb/tb_spatial_encoder.sv
// Self-checking bench for spatial_encoder with num_channel=4: fixed vector
// table, stall/gap/reset sequences, and random frames against a vote model.
`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif

module tb_spatial_encoder;
  localparam int D   = `HV_DIMENSION;
  localparam int NCH = 4;

  typedef logic [NCH-1:0][D-1:0] frame_t;
  typedef struct {
    frame_t       im;
    frame_t       pj;
    logic [D-1:0] exp;
  } vec_t;

  logic         clk, rst;
  logic [D-1:0] im, projm, hvout;
  logic         din_valid, din_ready, dout_valid, dout_ready;

  int errors = 0;
  int checks = 0;

  spatial_encoder #(.num_channel(NCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .im         (im),
    .projm      (projm),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .hvout      (hvout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Majority of ones across channels per dimension; ties lose.
  function automatic logic [D-1:0] model(input frame_t a, input frame_t b);
    logic [D-1:0] r;
    for (int d = 0; d < D; d++) begin
      int n = 0;
      for (int c = 0; c < NCH; c++) n += (a[c][d] ^ b[c][d]) ? 1 : 0;
      r[d] = (n * 2 > NCH);
    end
    return r;
  endfunction

  function automatic logic [D-1:0] rnd_hv();
    logic [D-1:0] v;
    for (int i = 0; i < D; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Presents one frame; with gaps, din_valid alternates 0/1 each cycle.
  task automatic send_frame(input frame_t ims, input frame_t pjs, input bit gaps, input string tag);
    for (int c = 0; c < NCH; c++) begin
      if (gaps) begin
        din_valid = 1'b0;
        im = rnd_hv();
        projm = rnd_hv();
        @(negedge clk);
      end
      chk1({tag, "_din_ready"}, din_ready, 1'b1);
      chk1({tag, "_early_vld"}, dout_valid, 1'b0);
      din_valid = 1'b1;
      im = ims[c];
      projm = pjs[c];
      @(negedge clk);
    end
    din_valid = 1'b0;
    chk1({tag, "_dout_valid"}, dout_valid, 1'b1);
    chk1({tag, "_ready_low"}, din_ready, 1'b0);
  endtask

  // Holds dout_ready low for `stall` cycles while upstream keeps pushing.
  task automatic drain(input logic [D-1:0] exp, input int stall, input string tag);
    for (int i = 0; i < stall; i++) begin
      din_valid = 1'b1;
      im = rnd_hv();
      projm = rnd_hv();
      chk({tag, "_hold_hv"}, hvout, exp);
      chk1({tag, "_hold_vld"}, dout_valid, 1'b1);
      chk1({tag, "_hold_rdy"}, din_ready, 1'b0);
      @(negedge clk);
    end
    din_valid = 1'b0;
    chk({tag, "_hvout"}, hvout, exp);
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    chk1({tag, "_vld_drop"}, dout_valid, 1'b0);
    chk1({tag, "_rdy_back"}, din_ready, 1'b1);
  endtask

  vec_t   tbl[7];
  frame_t fi, fp;
  logic [D-1:0] ones, f0, b5, b01, b012, e;

  initial begin
    ones = '1;
    f0   = {(D/8){8'hF0}};
    b5   = '0; b5[5] = 1'b1;
    b01  = '0; b01[1:0] = 2'b11;
    b012 = '0; b012[1] = 1'b1;

    tbl[0].im = {ones, ones, ones, ones};         tbl[0].pj = '0;                          tbl[0].exp = ones;
    tbl[1].im = {{D{1'b0}}, b012, b01, b01};      tbl[1].pj = '0;                          tbl[1].exp = b012;
    tbl[2].im = '0;                               tbl[2].pj = '0;                          tbl[2].exp = '0;
    tbl[3].im = {{D{1'b0}}, ones, ones, ones};    tbl[3].pj = '0;                          tbl[3].exp = ones;
    tbl[4].im = {{D{1'b0}}, {D{1'b0}}, ones, ones}; tbl[4].pj = '0;                        tbl[4].exp = '0;
    tbl[5].im = {ones, ones, ones, ones};         tbl[5].pj = {ones, ones, ones, ones};    tbl[5].exp = '0;
    tbl[6].im = {ones, f0, {D{1'b0}}, ones};      tbl[6].pj = {ones, {D{1'b0}}, f0, ~f0};  tbl[6].exp = f0;

    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; im = '0; projm = '0;
    repeat (2) @(negedge clk);
    chk("rst_hvout", hvout, '0);
    chk1("rst_dout_valid", dout_valid, 1'b0);
    chk1("rst_din_ready", din_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Fixed vectors back-to-back; entry 0 then 2 covers ones-then-zeros clear.
    for (int v = 0; v < 7; v++) begin
      chk($sformatf("tbl%0d_model", v), model(tbl[v].im, tbl[v].pj), tbl[v].exp);
      send_frame(tbl[v].im, tbl[v].pj, 1'b0, $sformatf("tbl%0d", v));
      drain(tbl[v].exp, 0, $sformatf("tbl%0d", v));
    end

    // Downstream stall with upstream pushing, then a zero frame proves the clear.
    send_frame(tbl[1].im, tbl[1].pj, 1'b0, "stall");
    drain(tbl[1].exp, 5, "stall");
    send_frame(tbl[2].im, tbl[2].pj, 1'b0, "post_stall");
    drain('0, 0, "post_stall");

    // Toggled din_valid must give the same result as the gapless frame.
    send_frame(tbl[6].im, tbl[6].pj, 1'b1, "gaps");
    drain(tbl[6].exp, 0, "gaps");

    // Reset after two fires discards the partial frame.
    for (int c = 0; c < 2; c++) begin
      din_valid = 1'b1; im = ones; projm = '0;
      @(negedge clk);
    end
    din_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_hvout", hvout, '0);
    chk1("midrst_vld", dout_valid, 1'b0);
    chk1("midrst_rdy", din_ready, 1'b1);
    #1 rst = 1'b0;
    @(negedge clk);
    fi = {{D{1'b0}}, b5, b5, b5};
    send_frame(fi, '0, 1'b0, "midrst");
    drain(b5, 0, "midrst");

    // Random frames with random gaps and stalls.
    for (int f = 0; f < 25; f++) begin
      for (int c = 0; c < NCH; c++) begin
        fi[c] = rnd_hv();
        fp[c] = rnd_hv();
      end
      e = model(fi, fp);
      send_frame(fi, fp, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", f));
      drain(e, int'($urandom_range(0, 3)), $sformatf("rnd%0d", f));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end
endmodule
